// File: rtl/ifetch_decode.sv
// Instruction fetch / pre-decode stage: PC, instruction register and repeat counter for the
// FETCH/EXEC1/EXEC2 sequencer. Repeat counter present only when IFETCH_DECODE_REPEAT_EN is defined.
module ifetch_decode #(
    parameter int PC_W = 8,
    parameter int IW   = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FETCH,
    input  logic            EXEC1,
    input  logic            EXEC2,
    input  logic [IW-1:0]   INS,
    input  logic            JUMP,
    input  logic [PC_W-1:0] JADDR,
    output logic [PC_W-1:0] PC,
    output logic [IW-1:0]   IR,
    output logic            EXTRA,
    output logic            P,
    output logic [3:0]      COUNT
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            state_ok;

    // Any state vector that is not one-hot freezes every register.
    assign state_ok = $onehot({FETCH, EXEC1, EXEC2});

    always_comb begin
        // NOTE: hold values assigned first so no path leaves a register undriven (no latches).
        pc_d = pc_q;
        ir_d = ir_q;
        if (state_ok) begin
            if (FETCH) begin
                ir_d = INS;
                pc_d = pc_q + PC_W'(1);
            end else if (EXEC1 && JUMP) begin
                pc_d = JADDR;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign PC    = pc_q;
    assign IR    = ir_q;
    assign EXTRA = ir_q[15];

`ifdef IFETCH_DECODE_REPEAT_EN
    logic [3:0] rep_q, rep_d;
    logic       rep_consult;

    // The count drops only in the cycle where the sequencer reads P for its exit decision.
    assign rep_consult = (EXEC1 && !ir_q[15]) || (EXEC2 && ir_q[15]);

    always_comb begin
        rep_d = rep_q;
        if (state_ok) begin
            if (FETCH) begin
                rep_d = INS[14] ? INS[3:0] : 4'd0;
            end else if (rep_consult && rep_q != 4'd0) begin
                rep_d = rep_q - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rep_q <= 4'd0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign P     = (rep_q != 4'd0);
    assign COUNT = rep_q;
`else
    assign P     = 1'b0;
    assign COUNT = 4'd0;
`endif

endmodule

// File: tb/tb_ifetch_decode.sv
// Scoreboard bench for ifetch_decode: the driver pushes model predictions, a monitor compares
// them against the registered outputs one cycle later.
module tb_ifetch_decode;

    localparam int PC_W = 8;
    localparam int IW   = 16;
`ifdef IFETCH_DECODE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic            FETCH = 1'b0;
    logic            EXEC1 = 1'b0;
    logic            EXEC2 = 1'b0;
    logic [IW-1:0]   INS = '0;
    logic            JUMP = 1'b0;
    logic [PC_W-1:0] JADDR = '0;
    logic [PC_W-1:0] PC;
    logic [IW-1:0]   IR;
    logic            EXTRA;
    logic            P;
    logic [3:0]      COUNT;

    ifetch_decode #(.PC_W(PC_W), .IW(IW)) dut (
        .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2),
        .INS(INS), .JUMP(JUMP), .JADDR(JADDR),
        .PC(PC), .IR(IR), .EXTRA(EXTRA), .P(P), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int pc;
        int ir;
        int extra;
        int p;
        int count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Architectural model in plain integers.
    int m_pc  = 0;
    int m_ir  = 0;
    int m_rep = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, want);
        end
    endtask

    task automatic model_step(input bit rst, input bit f, input bit e1, input bit e2,
                              input int ins, input bit jmp, input int ja);
        int n_active;
        int extra;
        n_active = int'(f) + int'(e1) + int'(e2);
        if (rst) begin
            m_pc = 0; m_ir = 0; m_rep = 0;
        end else if (n_active == 1) begin
            extra = (m_ir >> 15) & 1;
            if (f) begin
                m_ir  = ins;
                m_pc  = (m_pc + 1) % (1 << PC_W);
                m_rep = (REP_EN && ((ins >> 14) & 1) == 1) ? (ins & 15) : 0;
            end else begin
                if (e1 && jmp) m_pc = ja;
                if (((e1 && extra == 0) || (e2 && extra == 1)) && m_rep > 0) m_rep = m_rep - 1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit f, input bit e1, input bit e2,
                        input int ins, input bit jmp = 1'b0, input int ja = 0);
        exp_t e;
        @(negedge CLK);
        RESET = rst; FETCH = f; EXEC1 = e1; EXEC2 = e2;
        INS = IW'(ins); JUMP = jmp; JADDR = PC_W'(ja);
        model_step(rst, f, e1, e2, ins, jmp, ja);
        e.pc = m_pc; e.ir = m_ir; e.extra = (m_ir >> 15) & 1;
        e.p = (m_rep != 0) ? 1 : 0; e.count = m_rep;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge that had stimulus behind it produces one observation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",    int'(PC),    e.pc);
                check("ir",    int'(IR),    e.ir);
                check("extra", int'(EXTRA), e.extra);
                check("p",     int'(P),     e.p);
                check("count", int'(COUNT), e.count);
            end
        end
    end

    initial begin
        int sel;
        step(1, 0, 0, 0, 16'h1234);
        step(1, 0, 0, 0, 16'h1234);

        // Reach PC=0x23 via a jump, then reset twice mid-EXEC1.
        step(0, 1, 0, 0, 16'h0000);
        step(0, 0, 1, 0, 16'h0000, 1, 8'h23);
        step(0, 1, 0, 0, 16'h4005);
        step(1, 0, 1, 0, 16'h0000, 1, 8'h77);
        step(1, 0, 1, 0, 16'h0000);

        // Plain fetch, then PC wrap from 0xFF.
        step(0, 1, 0, 0, 16'h0000);
        step(0, 0, 1, 0, 16'h0000, 1, 8'hFF);
        step(0, 1, 0, 0, 16'h0000);
        step(0, 0, 1, 0, 16'h0000);

        // Repeat, non-EXTRA: k=3 gives four EXEC1 passes.
        step(0, 1, 0, 0, 16'h4003);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'h0000);
        step(0, 0, 1, 0, 16'h0000);

        // Repeat, EXTRA: k=2 gives three EXEC1/EXEC2 pairs; jump mid-repeat, last wins.
        step(0, 1, 0, 0, 16'hC002);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 16'h0000, 1, 8'h10 + i);
            step(0, 0, 0, 1, 16'h0000, 1, 8'h99);
        end

        // Jump in EXEC1 takes effect; jump in FETCH / EXEC2 does not.
        step(0, 1, 0, 0, 16'h0000, 1, 8'h55);
        step(0, 0, 1, 0, 16'h0000, 1, 8'h40);
        step(0, 0, 0, 1, 16'h0000, 1, 8'h66);

        // Illegal state vectors hold everything.
        step(0, 1, 1, 0, 16'hFFFF, 1, 8'hAA);
        step(0, 0, 0, 0, 16'hFFFF, 1, 8'hAA);
        step(0, 1, 1, 1, 16'hFFFF, 1, 8'hAA);
        step(0, 1, 0, 1, 16'hFFFF);

        // Saturation: k=0 repeat and a repeat held beyond its count.
        step(0, 1, 0, 0, 16'h4000);
        step(0, 0, 1, 0, 16'h0000);
        step(0, 1, 0, 0, 16'h4001);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'h0000);

        // Randomized sequencer-like traffic with occasional illegal states and resets.
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 2) begin
                step(1, 0, 0, 0, $urandom_range(0, 65535));
            end else if (sel < 10) begin
                step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 65535),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 255));
            end else begin
                sel = $urandom_range(0, 2);
                step(0, sel == 0, sel == 1, sel == 2, $urandom_range(0, 65535),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 255));
            end
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
